// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: per-requester one-entry holding buffers,
// round-robin grant into a registered write port, and a per-register busy vector.

module regfile_wb_slot #(
  parameter int addr_size = 4,
  parameter int data_size = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 acc,
  input  logic                 gnt,
  input  logic [addr_size-1:0] in_addr,
  input  logic [data_size-1:0] in_data,
  output logic                 full,
  output logic [addr_size-1:0] addr,
  output logic [data_size-1:0] data
);
  // Writes to r0 are accepted but never held, so they can't stall anyone.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      full <= 1'b0;
      addr <= '0;
      data <= '0;
    end else if (acc && |in_addr) begin
      full <= 1'b1;
      addr <= in_addr;
      data <= in_data;
    end else if (gnt) begin
      full <= 1'b0;
    end
  end
endmodule

module regfile_wb_arbiter #(
  parameter int addr_size = 4,
  parameter int data_size = 16,
  parameter int n_req     = 2
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [n_req-1:0]               req_valid,
  output logic [n_req-1:0]               req_ready,
  input  logic [n_req*addr_size-1:0]     req_addr,
  input  logic [n_req*data_size-1:0]     req_data,
  output logic                           wenable,
  output logic [addr_size-1:0]           waddr,
  output logic [data_size-1:0]           wdata,
  output logic [(1<<addr_size)-1:0]      busy
);
  localparam int LW = (n_req > 1) ? $clog2(n_req) : 1;

  logic [n_req-1:0]                full, gnt, acc;
  logic [n_req-1:0][addr_size-1:0] baddr, raddr;
  logic [n_req-1:0][data_size-1:0] bdata, rdata;
  logic [LW-1:0]                   last_grant, gidx;

  assign raddr = req_addr;
  assign rdata = req_data;
  assign acc   = req_valid & req_ready;

  for (genvar i = 0; i < n_req; i++) begin : g_slot
    regfile_wb_slot #(.addr_size(addr_size), .data_size(data_size)) u_slot (
      .clk(clk), .rstn(rstn), .acc(acc[i]), .gnt(gnt[i]),
      .in_addr(raddr[i]), .in_data(rdata[i]),
      .full(full[i]), .addr(baddr[i]), .data(bdata[i])
    );
  end

  // Round-robin: scan starting just after the last winner.
  always_comb begin
    int c;
    c    = 0;
    gnt  = '0;
    gidx = '0;
    for (int k = 1; k <= n_req; k++) begin
      c = (int'(last_grant) + k) % n_req;
      if (!(|gnt) && full[c]) begin
        gnt[c] = 1'b1;
        gidx   = LW'(c);
      end
    end
  end

  // Ready blocks any second pending write to the same register, keeping
  // per-register ordering without a compare against the output stage.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < n_req; i++) begin
      req_ready[i] = rstn && (!full[i] || gnt[i]);
      if (|raddr[i]) begin
        for (int j = 0; j < n_req; j++) begin
          if (j != i && full[j] && baddr[j] == raddr[i]) req_ready[i] = 1'b0;
          if (j < i && req_valid[j] && raddr[j] == raddr[i]) req_ready[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wenable    <= 1'b0;
      waddr      <= '0;
      wdata      <= '0;
      last_grant <= LW'(n_req - 1);
    end else begin
      wenable <= |gnt;
      if (|gnt) begin
        waddr      <= baddr[gidx];
        wdata      <= bdata[gidx];
        last_grant <= gidx;
      end
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < n_req; i++)
      if (full[i]) busy[baddr[i]] = 1'b1;
    if (wenable) busy[waddr] = 1'b1;
    busy[0] = 1'b0;
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized + directed bench for regfile_wb_arbiter against a
// transaction-level model of buffers, round-robin pointer and output stage.

module tb_regfile_wb_arbiter;
  localparam int AW = 4;
  localparam int DW = 16;
  localparam int N  = 3;

  logic                  clk = 1'b0;
  logic                  rstn = 1'b0;
  logic [N-1:0]          req_valid = '0;
  logic [N-1:0]          req_ready;
  logic [N*AW-1:0]       req_addr = '0;
  logic [N*DW-1:0]       req_data = '0;
  logic                  wenable;
  logic [AW-1:0]         waddr;
  logic [DW-1:0]         wdata;
  logic [(1<<AW)-1:0]    busy;

  regfile_wb_arbiter #(.addr_size(AW), .data_size(DW), .n_req(N)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .wenable(wenable),
    .waddr(waddr), .wdata(wdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // stimulus
  bit v[N];
  int a[N], d[N];
  bit acc[N];
  // model state
  bit m_full[N];
  int m_addr[N], m_data[N];
  int m_lg;
  bit m_we;
  int m_wa, m_wd;

  function automatic void m_reset();
    for (int i = 0; i < N; i++) begin
      m_full[i] = 0; m_addr[i] = 0; m_data[i] = 0; acc[i] = 1;
    end
    m_lg = N - 1; m_we = 0; m_wa = 0; m_wd = 0;
  endfunction

  function automatic int m_winner();
    for (int k = 1; k <= N; k++)
      if (m_full[(m_lg + k) % N]) return (m_lg + k) % N;
    return -1;
  endfunction

  function automatic bit m_ready(int i);
    if (!rstn) return 0;
    if (m_full[i] && m_winner() != i) return 0;
    if (a[i] == 0) return 1;
    for (int j = 0; j < N; j++) begin
      if (j != i && m_full[j] && m_addr[j] == a[i]) return 0;
      if (j < i && v[j] && a[j] == a[i]) return 0;
    end
    return 1;
  endfunction

  function automatic void m_step();
    bit r[N];
    int g;
    if (!rstn) return;
    for (int i = 0; i < N; i++) r[i] = m_ready(i);
    g = m_winner();
    if (g >= 0) begin
      m_we = 1; m_wa = m_addr[g]; m_wd = m_data[g]; m_full[g] = 0; m_lg = g;
    end else m_we = 0;
    for (int i = 0; i < N; i++) begin
      acc[i] = v[i] && r[i];
      if (acc[i] && a[i] != 0) begin
        m_full[i] = 1; m_addr[i] = a[i]; m_data[i] = d[i];
      end
    end
  endfunction

  function automatic int m_busy();
    int b = 0;
    for (int i = 0; i < N; i++) if (m_full[i]) b |= (1 << m_addr[i]);
    if (m_we) b |= (1 << m_wa);
    return b & ~1;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = v[i];
      req_addr[i*AW +: AW]  = AW'(a[i]);
      req_data[i*DW +: DW]  = DW'(d[i]);
    end
    #1;
    for (int i = 0; i < N; i++) chk($sformatf("ready%0d", i), 32'(req_ready[i]), 32'(m_ready(i)));
  endtask

  task automatic tick();
    @(posedge clk);
    m_step();
    @(negedge clk);
    chk("wenable", 32'(wenable), 32'(m_we));
    if (m_we) begin
      chk("waddr", 32'(waddr), m_wa);
      chk("wdata", 32'(wdata), m_wd);
    end
    chk("busy", 32'(busy), m_busy());
  endtask

  task automatic idle(int n);
    for (int i = 0; i < N; i++) v[i] = 0;
    drive();
    repeat (n) tick();
  endtask

  initial begin
    m_reset();
    for (int i = 0; i < N; i++) begin v[i] = 1; a[i] = i + 1; d[i] = 0; end
    drive();
    chk("rst_wenable", 32'(wenable), 0);
    chk("rst_waddr", 32'(waddr), 0);
    chk("rst_wdata", 32'(wdata), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(req_ready), 0);
    @(negedge clk);
    rstn = 1'b1;

    // single write
    v = '{1, 0, 0}; a[0] = 5; d[0] = 'h1234;
    drive();
    chk("first_ready0", 32'(req_ready[0]), 1);
    tick();
    chk("single_busy5_c1", 32'(busy[5]), 1);
    chk("single_we_c1", 32'(wenable), 0);
    idle(1);
    chk("single_we", 32'(wenable), 1);
    chk("single_waddr", 32'(waddr), 5);
    chk("single_wdata", 32'(wdata), 'h1234);
    tick();
    chk("single_we_off", 32'(wenable), 0);
    chk("single_busy5_off", 32'(busy[5]), 0);

    // round-robin with two continuously valid requesters
    v = '{1, 1, 0}; a[0] = 1; a[1] = 2; d[0] = 'hAAAA; d[1] = 'hBBBB;
    drive();
    repeat (6) begin tick(); drive(); end
    idle(3);

    // same-address hazard
    v = '{1, 1, 0}; a[0] = 7; a[1] = 7; d[0] = 'h0707; d[1] = 'h7070;
    drive();
    chk("haz_ready1", 32'(req_ready[1]), 0);
    tick(); v[0] = 0; drive();
    tick(); drive();
    tick(); v[1] = 0; drive();
    repeat (3) tick();

    // address-0 discard
    v = '{0, 1, 0}; a[1] = 0; d[1] = 'hFFFF;
    drive();
    chk("a0_ready1", 32'(req_ready[1]), 1);
    tick(); v[1] = 0; drive();
    repeat (2) begin
      tick();
      chk("a0_we", 32'(wenable), 0);
      chk("a0_busy", 32'(busy), 0);
    end

    // back-to-back single requester
    for (int k = 3; k <= 5; k++) begin
      v = '{1, 0, 0}; a[0] = k; d[0] = 'h100 + k;
      drive();
      chk("b2b_ready0", 32'(req_ready[0]), 1);
      tick();
    end
    idle(1);
    chk("b2b_last_waddr", 32'(waddr), 5);
    idle(2);

    // reset mid-flight with two buffers full
    v = '{1, 1, 0}; a[0] = 1; a[1] = 2; d[0] = 'h1111; d[1] = 'h2222;
    drive();
    tick();
    v = '{0, 0, 0}; drive();
    tick();
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_we", 32'(wenable), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_ready", 32'(req_ready), 0);
    m_reset();
    @(negedge clk);
    rstn = 1'b1;
    idle(2);
    v = '{1, 1, 0}; a[0] = 3; a[1] = 4; d[0] = 'h3333; d[1] = 'h4444;
    drive();
    tick(); v = '{0, 0, 0}; drive();
    tick();
    chk("post_rst_first_waddr", 32'(waddr), 3);
    idle(3);

    // randomized traffic; stalled requesters hold their request
    for (int i = 0; i < N; i++) acc[i] = 1;
    repeat (400) begin
      for (int i = 0; i < N; i++)
        if (!(v[i] && !acc[i])) begin
          v[i] = ($urandom % 10) < 7;
          a[i] = $urandom_range(0, 5);
          d[i] = $urandom & 'hFFFF;
        end
      drive();
      tick();
    end
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
